wb_retire: RTL and testbench

- Writeback-side consumer of the MEM/WB pipeline register bundle.
- Turns held MEM/WB fields into architectural commits: RF write with load extraction and merge, HI/LO writes, and CP0 writes.
- Serializes a TLBR result into four CP0 writes under an FSM, holding MEM/WB through wb_stall while it does so.
- Emits one retire pulse per instruction.

---
 rtl/wb_pkg.sv | 49 ++++
 rtl/wb_retire_load_align.sv | 48 ++++
 rtl/wb_retire.sv | 192 +++++++++++++++++++
 tb/tb_wb_retire.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback retire stage: load kinds, RF source
// selects, TLBR serializer states, CP0 register numbers and tlbr_result layout.
package wb_pkg;

  localparam int          WB_TLBR_W          = 90;
  localparam logic [4:0]  WB_CP0_PAGEMASK    = 5'd5;
  localparam logic [4:0]  WB_CP0_ENTRYHI     = 5'd10;
  localparam logic [4:0]  WB_CP0_ENTRYLO0    = 5'd2;
  localparam logic [4:0]  WB_CP0_ENTRYLO1    = 5'd3;

  // tlbr_result = {mask[11:0], vpn2[18:0], asid[7:0], g, lo0[24:0], lo1[24:0]}
  localparam int TLBR_LO1_LSB  = 0;
  localparam int TLBR_LO0_LSB  = 25;
  localparam int TLBR_G_BIT    = 50;
  localparam int TLBR_ASID_LSB = 51;
  localparam int TLBR_VPN2_LSB = 59;
  localparam int TLBR_MASK_LSB = 78;

  typedef enum logic [3:0] {
    LD_NONE = 4'd0,
    LD_LB   = 4'd1,
    LD_LBU  = 4'd2,
    LD_LH   = 4'd3,
    LD_LHU  = 4'd4,
    LD_LW   = 4'd5,
    LD_LWL  = 4'd6,
    LD_LWR  = 4'd7
  } load_t;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_LOAD = 2'd1,
    RES_LINK = 2'd2,
    RES_SC   = 2'd3
  } res_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_T_HI  = 2'd1,
    ST_T_LO0 = 2'd2,
    ST_T_LO1 = 2'd3
  } wb_state_t;

  // EntryLo layout: {6'b0, pfn[19:0], c[2:0], d, v, g}
  function automatic logic [31:0] entrylo(input logic [24:0] lo, input logic g);
    return {6'b0, lo, g};
  endfunction

endpackage

// File: rtl/wb_retire_load_align.sv
// Combinational load extraction: byte/halfword extension and LWL/LWR merge
// into the old rt value, little-endian lane numbering.
module wb_retire_load_align
  import wb_pkg::*;
(
  input  logic [3:0]  load_type,
  input  logic [1:0]  offset,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] rt,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = mem_rdata[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    data = mem_rdata;
    case (load_type)
      LD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: data = {24'b0, byte_sel};
      LD_LH:  data = {{16{half_sel[15]}}, half_sel};
      LD_LHU: data = {16'b0, half_sel};
      LD_LW:  data = mem_rdata;
      // LWL fills from the top down, LWR from the bottom up; untouched lanes keep rt
      LD_LWL: begin
        case (offset)
          2'd0:    data = {mem_rdata[7:0],  rt[23:0]};
          2'd1:    data = {mem_rdata[15:0], rt[15:0]};
          2'd2:    data = {mem_rdata[23:0], rt[7:0]};
          default: data = mem_rdata;
        endcase
      end
      LD_LWR: begin
        case (offset)
          2'd0:    data = mem_rdata;
          2'd1:    data = {rt[31:24], mem_rdata[31:8]};
          2'd2:    data = {rt[31:16], mem_rdata[31:16]};
          default: data = {rt[31:8],  mem_rdata[31:24]};
        endcase
      end
      default: data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/wb_retire.sv
// Writeback retire stage: RF/HI/LO/CP0 commits and a 4-cycle TLBR serializer.
// Optional trace outputs enabled by defining WB_DEBUG_TRACE_EN.
module wb_retire
  import wb_pkg::*;
#(
  parameter int         TLBR_W       = WB_TLBR_W,
  parameter logic [4:0] CP0_PAGEMASK = WB_CP0_PAGEMASK,
  parameter logic [4:0] CP0_ENTRYHI  = WB_CP0_ENTRYHI,
  parameter logic [4:0] CP0_ENTRYLO0 = WB_CP0_ENTRYLO0,
  parameter logic [4:0] CP0_ENTRYLO1 = WB_CP0_ENTRYLO1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic              wreg,
  input  logic              whi,
  input  logic              wlo,
  input  logic              wcp0,
  input  logic              tlbr,
  input  logic              hi_i_sel,
  input  logic              lo_i_sel,
  input  logic              SC_result_sel,
  input  logic [1:0]        result_sel,
  input  logic [3:0]        load_type,
  input  logic [3:0]        byte_valid,
  input  logic [4:0]        regdst,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       mem_rdata,
  input  logic [31:0]       rf_rdata0_fw,
  input  logic [31:0]       rf_rdata1_fw,
  input  logic [31:0]       PC_plus4,
  input  logic [31:0]       instruction,
  input  logic [63:0]       MulDiv_result,
  input  logic [TLBR_W-1:0] tlbr_result,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              hi_we,
  output logic              lo_we,
  output logic [31:0]       hi_wdata,
  output logic [31:0]       lo_wdata,
  output logic              cp0_we,
  output logic [4:0]        cp0_waddr,
  output logic [31:0]       cp0_wdata,
  output logic              wb_stall,
`ifdef WB_DEBUG_TRACE_EN
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata,
`endif
  output logic              retire
);

  wb_state_t   state_q, state_d;
  logic        cp0_we_d, stall_d;
  logic [4:0]  cp0_waddr_d;
  logic [31:0] cp0_wdata_d;
  logic [31:0] load_data;
  logic [31:0] rf_wdata_d;

  logic [11:0] t_mask;
  logic [18:0] t_vpn2;
  logic [7:0]  t_asid;
  logic        t_g;
  logic [24:0] t_lo0, t_lo1;

  assign t_mask = tlbr_result[TLBR_MASK_LSB +: 12];
  assign t_vpn2 = tlbr_result[TLBR_VPN2_LSB +: 19];
  assign t_asid = tlbr_result[TLBR_ASID_LSB +: 8];
  assign t_g    = tlbr_result[TLBR_G_BIT];
  assign t_lo0  = tlbr_result[TLBR_LO0_LSB +: 25];
  assign t_lo1  = tlbr_result[TLBR_LO1_LSB +: 25];

  wb_retire_load_align u_load_align (
    .load_type (load_type),
    .offset    (ALU_result[1:0]),
    .mem_rdata (mem_rdata),
    .rt        (rf_rdata1_fw),
    .data      (load_data)
  );

  always_comb begin
    state_d     = state_q;
    cp0_we_d    = 1'b0;
    cp0_waddr_d = 5'd0;
    cp0_wdata_d = 32'd0;
    stall_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_valid && tlbr) begin
          cp0_we_d    = 1'b1;
          cp0_waddr_d = CP0_PAGEMASK;
          cp0_wdata_d = {7'b0, t_mask, 13'b0};
          stall_d     = 1'b1;
          state_d     = ST_T_HI;
        end else if (wb_valid && wcp0) begin
          cp0_we_d    = 1'b1;
          cp0_waddr_d = instruction[15:11];
          cp0_wdata_d = rf_rdata1_fw;
        end
      end
      ST_T_HI: begin
        cp0_we_d    = 1'b1;
        cp0_waddr_d = CP0_ENTRYHI;
        cp0_wdata_d = {t_vpn2, 5'b0, t_asid};
        stall_d     = 1'b1;
        state_d     = ST_T_LO0;
      end
      ST_T_LO0: begin
        cp0_we_d    = 1'b1;
        cp0_waddr_d = CP0_ENTRYLO0;
        cp0_wdata_d = entrylo(t_lo0, t_g);
        stall_d     = 1'b1;
        state_d     = ST_T_LO1;
      end
      default: begin
        cp0_we_d    = 1'b1;
        cp0_waddr_d = CP0_ENTRYLO1;
        cp0_wdata_d = entrylo(t_lo1, t_g);
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rf_wdata_d = ALU_result;
    case (result_sel)
      RES_ALU:  rf_wdata_d = ALU_result;
      RES_LOAD: rf_wdata_d = load_data;
      RES_LINK: rf_wdata_d = PC_plus4 + 32'd4;
      default:  rf_wdata_d = {31'b0, SC_result_sel};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are forced low while reset is held so a mid-TLBR reset drops them at once
  assign wb_stall  = rst_n && stall_d;
  assign cp0_we    = rst_n && cp0_we_d;
  assign cp0_waddr = rst_n ? cp0_waddr_d : 5'd0;
  assign cp0_wdata = rst_n ? cp0_wdata_d : 32'd0;
  assign retire    = rst_n && wb_valid && !stall_d;
  assign rf_we     = rst_n && wb_valid && wreg && (regdst != 5'd0) && !stall_d;
  assign rf_waddr  = rst_n ? regdst : 5'd0;
  assign rf_wdata  = rst_n ? rf_wdata_d : 32'd0;
  assign hi_we     = rst_n && wb_valid && whi;
  assign lo_we     = rst_n && wb_valid && wlo;
  assign hi_wdata  = !rst_n ? 32'd0 : (hi_i_sel ? rf_rdata0_fw : MulDiv_result[63:32]);
  assign lo_wdata  = !rst_n ? 32'd0 : (lo_i_sel ? rf_rdata0_fw : MulDiv_result[31:0]);

`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] dbg_pc_q;
  logic [3:0]  dbg_wen_q;
  logic [4:0]  dbg_wnum_q;
  logic [31:0] dbg_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_pc_q    <= 32'd0;
      dbg_wen_q   <= 4'd0;
      dbg_wnum_q  <= 5'd0;
      dbg_wdata_q <= 32'd0;
    end else begin
      dbg_wen_q <= rf_we ? byte_valid : 4'd0;
      if (retire) begin
        dbg_pc_q    <= PC_plus4 - 32'd4;
        dbg_wnum_q  <= rf_waddr;
        dbg_wdata_q <= rf_wdata;
      end
    end
  end

  assign debug_wb_pc       = dbg_pc_q;
  assign debug_wb_rf_wen   = dbg_wen_q;
  assign debug_wb_rf_wnum  = dbg_wnum_q;
  assign debug_wb_rf_wdata = dbg_wdata_q;

  logic unused_instr;
  assign unused_instr = ^{instruction[31:16], instruction[10:0]};
`else
  logic unused_instr;
  assign unused_instr = ^{instruction[31:16], instruction[10:0], byte_valid};
`endif

endmodule

// File: tb/tb_wb_retire.sv
// Scoreboard bench for wb_retire: stimulus queues expected commit cycles,
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_wb_retire;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, wreg, whi, wlo, wcp0, tlbr, hi_i_sel, lo_i_sel, SC_result_sel;
  logic [1:0]  result_sel;
  logic [3:0]  load_type, byte_valid;
  logic [4:0]  regdst;
  logic [31:0] ALU_result, mem_rdata, rf_rdata0_fw, rf_rdata1_fw, PC_plus4, instruction;
  logic [63:0] MulDiv_result;
  logic [89:0] tlbr_result;
  logic        rf_we, hi_we, lo_we, cp0_we, wb_stall, retire;
  logic [4:0]  rf_waddr, cp0_waddr;
  logic [31:0] rf_wdata, hi_wdata, lo_wdata, cp0_wdata;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
`endif

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hi_we;
    logic [31:0] hi_wdata;
    logic        lo_we;
    logic [31:0] lo_wdata;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        wb_stall;
    logic        retire;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic expect_quiet = 1'b1;
  logic final_check  = 1'b0;

  always #5 clk = ~clk;

  wb_retire dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wreg(wreg), .whi(whi), .wlo(wlo),
    .wcp0(wcp0), .tlbr(tlbr), .hi_i_sel(hi_i_sel), .lo_i_sel(lo_i_sel),
    .SC_result_sel(SC_result_sel), .result_sel(result_sel), .load_type(load_type),
    .byte_valid(byte_valid), .regdst(regdst), .ALU_result(ALU_result),
    .mem_rdata(mem_rdata), .rf_rdata0_fw(rf_rdata0_fw), .rf_rdata1_fw(rf_rdata1_fw),
    .PC_plus4(PC_plus4), .instruction(instruction), .MulDiv_result(MulDiv_result),
    .tlbr_result(tlbr_result), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .wb_stall(wb_stall),
`ifdef WB_DEBUG_TRACE_EN
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
`endif
    .retire(retire)
  );

  function automatic obs_t ex(input logic rw, input logic [4:0] ra, input logic [31:0] rd,
                              input logic hw, input logic [31:0] hd,
                              input logic lw, input logic [31:0] ld,
                              input logic cw, input logic [4:0] ca, input logic [31:0] cd,
                              input logic st, input logic rt);
    obs_t o;
    o.rf_we = rw;  o.rf_waddr = ra;  o.rf_wdata = rd;
    o.hi_we = hw;  o.hi_wdata = hd;
    o.lo_we = lw;  o.lo_wdata = ld;
    o.cp0_we = cw; o.cp0_waddr = ca; o.cp0_wdata = cd;
    o.wb_stall = st; o.retire = rt;
    return o;
  endfunction

  // Payload fields are zeroed when their enable is low so only live data is compared
  always @(negedge clk) begin
    obs_t act, e;
    act.rf_we     = rf_we;
    act.rf_waddr  = rf_we ? rf_waddr : 5'd0;
    act.rf_wdata  = rf_we ? rf_wdata : 32'd0;
    act.hi_we     = hi_we;
    act.hi_wdata  = hi_we ? hi_wdata : 32'd0;
    act.lo_we     = lo_we;
    act.lo_wdata  = lo_we ? lo_wdata : 32'd0;
    act.cp0_we    = cp0_we;
    act.cp0_waddr = cp0_we ? cp0_waddr : 5'd0;
    act.cp0_wdata = cp0_we ? cp0_wdata : 32'd0;
    act.wb_stall  = wb_stall;
    act.retire    = retire;
    if (final_check) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL leftover: %0d expected commit cycles never seen, required 0", exp_q.size());
      end
    end else if (expect_quiet) begin
      n_cmp++;
      if (act != '0 || rf_wdata != 32'd0 || cp0_wdata != 32'd0) begin
        n_bad++;
        $display("FAIL quiet: got %h rf_wdata=%h cp0_wdata=%h, required all zero",
                 act, rf_wdata, cp0_wdata);
      end
    end else if (rf_we || hi_we || lo_we || cp0_we || wb_stall || retire) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected: got activity %h, required none", act);
      end else begin
        e = exp_q.pop_front();
        if (act != e) begin
          n_bad++;
          $display("FAIL commit: got %h, required %h", act, e);
        end else begin
          $display("commit %0d ok: rf=%0d/%h cp0=%0d/%h stall=%0b retire=%0b",
                   n_cmp, act.rf_waddr, act.rf_wdata, act.cp0_waddr, act.cp0_wdata,
                   act.wb_stall, act.retire);
        end
      end
    end
  end

  task automatic clr();
    wb_valid = 0; wreg = 0; whi = 0; wlo = 0; wcp0 = 0; tlbr = 0;
    hi_i_sel = 0; lo_i_sel = 0; SC_result_sel = 0; result_sel = 2'd0;
    load_type = 4'd0; byte_valid = 4'hF; regdst = 5'd0;
    ALU_result = 32'd0; mem_rdata = 32'd0; rf_rdata0_fw = 32'd0; rf_rdata1_fw = 32'd0;
    PC_plus4 = 32'd0; instruction = 32'd0; MulDiv_result = 64'd0; tlbr_result = '0;
  endtask

  // Hold one instruction in MEM/WB for n cycles, then drop it
  task automatic go(input int n);
    wb_valid = 1;
    repeat (n) @(posedge clk);
    #1;
    clr();
  endtask

  task automatic load(input logic [3:0] lt, input logic [1:0] off, input logic [31:0] md,
                      input logic [31:0] rt, input logic [4:0] rd, input logic [31:0] want);
    result_sel = 2'd1; wreg = 1; regdst = rd; load_type = lt;
    ALU_result = {30'h0400_0000, off}; mem_rdata = md; rf_rdata1_fw = rt;
    exp_q.push_back(ex(1, rd, want, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    go(1);
  endtask

  localparam logic [89:0] TLBR_VEC = {12'hFFF, 19'h12345, 8'h5A, 1'b1, 25'h1579BCF, 25'h0000249};

  initial begin
    clr();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1 expect_quiet = 0;

    load(4'd1, 2'd3, 32'h80FF_1234, 32'h0, 5'd5, 32'hFFFF_FF80);      // LB
    load(4'd6, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 5'd8, 32'hCCDD_3344); // LWL
    load(4'd7, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 5'd8, 32'h11AA_BBCC); // LWR
    load(4'd3, 2'd2, 32'h80FF_1234, 32'h0, 5'd9, 32'hFFFF_80FF);      // LH
    load(4'd4, 2'd2, 32'h80FF_1234, 32'h0, 5'd9, 32'h0000_80FF);      // LHU
    load(4'd2, 2'd1, 32'h80FF_1234, 32'h0, 5'd10, 32'h0000_0012);     // LBU
    load(4'd5, 2'd2, 32'h80FF_1234, 32'h0, 5'd11, 32'h80FF_1234);     // LW

    // MULT
    whi = 1; wlo = 1; MulDiv_result = 64'h0000_0001_FFFF_FFFE;
    exp_q.push_back(ex(0, 0, 0, 1, 32'h1, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 1));
    go(1);

    // MTHI
    whi = 1; hi_i_sel = 1; rf_rdata0_fw = 32'h5555_AAAA; MulDiv_result = 64'h1234_5678_9ABC_DEF0;
    exp_q.push_back(ex(0, 0, 0, 1, 32'h5555_AAAA, 0, 0, 0, 0, 0, 0, 1));
    go(1);

    // TLBR
    tlbr = 1; tlbr_result = TLBR_VEC;
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 1, 5'd5,  32'h01FF_E000, 1, 0));
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 1, 5'd10, 32'h2468_A05A, 1, 0));
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 1, 5'd2,  32'h02AF_379F, 1, 0));
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 1, 5'd3,  32'h0000_0493, 0, 1));
    go(4);

    // JAL to r31, then to r0
    result_sel = 2'd2; wreg = 1; regdst = 5'd31; PC_plus4 = 32'hBFC0_0004;
    exp_q.push_back(ex(1, 5'd31, 32'hBFC0_0008, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    go(1);
    result_sel = 2'd2; wreg = 1; regdst = 5'd0; PC_plus4 = 32'hBFC0_0004;
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    go(1);

    // MTC0 to register 12
    wcp0 = 1; instruction = 32'h4080_6000; rf_rdata1_fw = 32'hDEAD_BEEF;
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 1, 5'd12, 32'hDEAD_BEEF, 0, 1));
    go(1);

    // SC success flag
    result_sel = 2'd3; SC_result_sel = 1; wreg = 1; regdst = 5'd4; ALU_result = 32'hFFFF_FFFF;
    exp_q.push_back(ex(1, 5'd4, 32'h0000_0001, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    go(1);

    // Invalid slot with every control set: no activity
    expect_quiet = 1;
    wreg = 1; whi = 1; wlo = 1; wcp0 = 1; tlbr = 1; regdst = 5'd7; tlbr_result = TLBR_VEC;
    repeat (3) @(posedge clk);
    #1 clr();
    expect_quiet = 0;

    // TLBR with reset asserted in T_LO0
    tlbr = 1; tlbr_result = TLBR_VEC;
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 1, 5'd5,  32'h01FF_E000, 1, 0));
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0, 1, 5'd10, 32'h2468_A05A, 1, 0));
    wb_valid = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 0; expect_quiet = 1;
    @(posedge clk);
    #1 clr();
    @(posedge clk);
    #1 rst_n = 1;
    repeat (4) @(posedge clk);
    #1 expect_quiet = 0;

    // ALU result after recovery
    wreg = 1; regdst = 5'd3; ALU_result = 32'h0000_BEEF;
    exp_q.push_back(ex(1, 5'd3, 32'h0000_BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    go(1);

    repeat (2) @(posedge clk);
    #1 final_check = 1;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
